csi2_raw10_unpacker: RTL and testbench
======================================

Name: csi2_raw10_unpacker

Overview:
- Sits directly upstream of the CSI2CPI async pixel FIFO, in the write clock domain.
- Takes the CSI-2 long-packet payload byte stream (RAW10, already header-stripped and lane-merged) and unpacks each 5-byte group into four 10-bit pixels.
- Writes the pixels into the FIFO write port with start-of-frame and end-of-line tags.
- The CSI-2 source cannot be stalled, so FIFO back-pressure is handled by dropping pixels and raising a sticky overflow flag.

Parameters:
- FIFO_WIDTH, 12, FIFO write-data width; fixed layout {eol, sof, pixel[9:0]}; must be >= 12, upper bits zero.
- CNT_WIDTH, 16, width of pixel_cnt_o.

Ports:
- wr_clk_i  in  1  FIFO write clock; all logic on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- byte_i  in  8  payload byte.
- byte_vld_i  in  1  byte_i valid this cycle; at most one byte per cycle.
- pkt_start_i  in  1  qualified by byte_vld_i; marks first payload byte of a line packet.
- pkt_end_i  in  1  qualified by byte_vld_i; marks last payload byte.
- frame_start_i  in  1  single-cycle pulse from the Frame Start short packet.
- full_o  in  1  FIFO full flag, from the FIFO.
- fifo_wr_en_o  out  1  FIFO write enable.
- fifo_wr_data_o  out  FIFO_WIDTH  {eol, sof, pixel}.
- overflow_o  out  1  sticky: a pixel was dropped because the FIFO was full.
- ovf_clr_i  in  1  clears overflow_o.
- err_len_o  out  1  one-cycle pulse: packet ended or was aborted on a non-5-byte boundary.
- pixel_cnt_o  out  CNT_WIDTH  pixels actually written for the current or last packet.

Behaviour:
- Reset:
  - All outputs are 0.
  - Byte index = 0, emitter idle, sof_pending = 0, group buffers cleared.
- Byte collection:
  - 3-bit byte index runs 0..4 on each accepted byte (byte_vld_i = 1).
  - pkt_start_i with byte_vld_i forces that byte to index 0.
  - Bytes 0..3 are stored as pixel MSBs; byte 4 carries the LSBs.
  - Unpacking rule: pixel k = {B_k, B4[2k+1:2k]}, for k = 0..3.
- Group handoff:
  - On acceptance of byte 4, the 4 pixels move into an output buffer and the index returns to 0.
  - Tags are captured at handoff:
    - eol = pkt_end_i on byte 4; applies to pixel 3 only.
    - sof = sof_pending, if this is the first group of the packet; applies to pixel 0 only.
- Emitter:
  - States IDLE, EMIT0..EMIT3.
  - Handoff takes IDLE to EMIT0; each state lasts exactly one cycle; EMIT3 returns to IDLE.
  - Latency: pixel 0 is presented the cycle after byte 4 is accepted.
  - A group takes at least 5 input cycles and emission takes 4, so handoff never collides with an active emission. No input stall exists.
- Write rules:
  - In EMITk: fifo_wr_en_o = ~full_o (combinational on full_o); fifo_wr_data_o is valid the whole state.
  - If full_o = 1, the pixel is dropped, the emitter still advances, and overflow_o is set.
  - overflow_o stays set until ovf_clr_i is asserted. When set and clear occur in the same cycle, set wins.
- sof_pending:
  - Set by frame_start_i.
  - Cleared when a sof-tagged pixel is emitted, whether written or dropped.
- Length errors (err_len_o pulses the cycle after the triggering byte):
  - pkt_end_i on a byte with index != 4: pulse, partial group discarded, index reset to 0.
  - pkt_start_i with index != 0 (missing end): pulse, partial group discarded, new packet begins with this byte.
  - pkt_start_i and pkt_end_i on the same byte: treated as the end-not-on-boundary case.
  - A group already in the output buffer always drains normally.
- pixel_cnt_o:
  - Cleared on an accepted pkt_start_i byte.
  - Increments on each fifo_wr_en_o and saturates at all-ones.
  - Holds its value after the packet ends.
- rst_i mid-packet or mid-emission: immediate abort, no further writes, all state returns to reset values.

Test Plan:
1. Stimulus: frame_start_i pulse, then a packet of bytes 0x12, 0x34, 0x56, 0x78, 0xE4 (start on first byte, end on last), full_o = 0.
   -> Four consecutive writes starting the cycle after 0xE4: 0x448, 0x0D1, 0x15A, 0x9E3.
   -> pixel_cnt_o = 4; err_len_o and overflow_o stay 0.
2. Stimulus: 640-pixel line (800 bytes) with random byte_vld_i gaps.
   -> 640 writes; eol only on write 640; no sof; pixel_cnt_o = 640; data matches the unpacking rule for every group.
3. Stimulus: same as 1, with full_o = 1 during the second emit cycle only.
   -> Writes 0x448, 0x15A, 0x9E3; overflow_o = 1 and held; pixel_cnt_o = 3.
   -> ovf_clr_i pulse clears overflow_o; ovf_clr_i concurrent with a new drop leaves it set.
4. Stimulus: 7-byte packet (end at index 1).
   -> One group written (4 writes, no eol); err_len_o pulses once; the next packet unpacks correctly from index 0.
5. Stimulus: pkt_start_i at index 3 of a packet.
   -> err_len_o pulses; the 3 partial bytes are discarded; the new packet's first group gives correct pixels.
6. Stimulus: rst_i asserted during EMIT1.
   -> fifo_wr_en_o = 0 immediately; no further writes; all outputs 0; the next packet after reset behaves as in scenario 1.

Source files
------------

// File: rtl/csi2_raw10_unpacker_if.sv
// Payload-byte input and FIFO write-port bundle for the RAW10 unpacker.
// Names follow the unpacker's view of each signal, so full_o is an input of the unpacker.
interface csi2_raw10_unpacker_if #(
    parameter int FIFO_WIDTH = 12
) ();
    logic [7:0]            byte_i;
    logic                  byte_vld_i;
    logic                  pkt_start_i;
    logic                  pkt_end_i;
    logic                  frame_start_i;
    logic                  full_o;
    logic                  fifo_wr_en_o;
    logic [FIFO_WIDTH-1:0] fifo_wr_data_o;

    modport slave (
        input  byte_i, byte_vld_i, pkt_start_i, pkt_end_i, frame_start_i, full_o,
        output fifo_wr_en_o, fifo_wr_data_o
    );

    modport master (
        output byte_i, byte_vld_i, pkt_start_i, pkt_end_i, frame_start_i, full_o,
        input  fifo_wr_en_o, fifo_wr_data_o
    );
endinterface

// File: rtl/csi2_raw10_unpacker.sv
// Unpacks CSI-2 RAW10 payload bytes (5 bytes -> 4 pixels) into the pixel FIFO write port.
// The source cannot stall, so a full FIFO drops pixels and raises a sticky overflow flag.
module csi2_raw10_unpacker #(
    parameter int FIFO_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 wr_clk_i,
    input  logic                 rst_i,
    csi2_raw10_unpacker_if.slave bus,
    output logic                 overflow_o,
    input  logic                 ovf_clr_i,
    output logic                 err_len_o,
    output logic [CNT_WIDTH-1:0] pixel_cnt_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EMIT0 = 3'd1,
        ST_EMIT1 = 3'd2,
        ST_EMIT2 = 3'd3,
        ST_EMIT3 = 3'd4
    } emit_state_e;

    emit_state_e           state_r;
    emit_state_e           state_s;
    logic [2:0]            byte_idx_r;
    logic [2:0]            eff_idx_s;
    logic [7:0]            msb_r [0:3];
    logic [9:0]            pix_buf_r [0:3];
    logic                  first_grp_r;
    logic                  sof_pending_r;
    logic                  sof_tag_r;
    logic                  eol_tag_r;
    logic                  store_s;
    logic                  handoff_s;
    logic                  drop_s;
    logic                  err_s;
    logic                  emit_s;
    logic                  wr_en_s;
    logic                  pkt_open_s;
    logic [FIFO_WIDTH-1:0] wr_data_s;

    // Classify each accepted byte: store, group handoff, or discard on a length error.
    always_comb begin
        eff_idx_s  = bus.pkt_start_i ? 3'd0 : byte_idx_r;
        store_s    = 1'b0;
        handoff_s  = 1'b0;
        drop_s     = 1'b0;
        err_s      = 1'b0;
        pkt_open_s = 1'b0;
        if (bus.byte_vld_i) begin
            pkt_open_s = bus.pkt_start_i;
            err_s      = (bus.pkt_end_i && (eff_idx_s != 3'd4)) ||
                         (bus.pkt_start_i && (byte_idx_r != 3'd0));
            if (bus.pkt_end_i && (eff_idx_s != 3'd4)) begin
                drop_s = 1'b1;
            end else if (eff_idx_s == 3'd4) begin
                handoff_s = 1'b1;
            end else begin
                store_s = 1'b1;
            end
        end else begin
            err_s = 1'b0;
        end
    end

    // Byte index and MSB collection buffer.
    always_ff @(posedge wr_clk_i or posedge rst_i) begin
        if (rst_i) begin
            byte_idx_r <= 3'd0;
            for (int k = 0; k < 4; k++) begin
                msb_r[k] <= 8'd0;
            end
        end else if (handoff_s || drop_s) begin
            byte_idx_r <= 3'd0;
        end else if (store_s) begin
            byte_idx_r            <= eff_idx_s + 3'd1;
            msb_r[eff_idx_s[1:0]] <= bus.byte_i;
        end else begin
            byte_idx_r <= byte_idx_r;
        end
    end

    // Output group buffer and its tags, loaded when the fifth byte arrives.
    always_ff @(posedge wr_clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < 4; k++) begin
                pix_buf_r[k] <= 10'd0;
            end
            sof_tag_r <= 1'b0;
            eol_tag_r <= 1'b0;
        end else if (handoff_s) begin
            for (int k = 0; k < 4; k++) begin
                pix_buf_r[k] <= {msb_r[k], bus.byte_i[2*k +: 2]};
            end
            sof_tag_r <= sof_pending_r & first_grp_r;
            eol_tag_r <= bus.pkt_end_i;
        end else begin
            sof_tag_r <= sof_tag_r;
        end
    end

    // First-group marker and frame-start tag pending until the sof pixel leaves.
    always_ff @(posedge wr_clk_i or posedge rst_i) begin
        if (rst_i) begin
            first_grp_r   <= 1'b0;
            sof_pending_r <= 1'b0;
        end else begin
            if (pkt_open_s) begin
                first_grp_r <= 1'b1;
            end else if (handoff_s) begin
                first_grp_r <= 1'b0;
            end else begin
                first_grp_r <= first_grp_r;
            end
            if (bus.frame_start_i) begin
                sof_pending_r <= 1'b1;
            end else if ((state_r == ST_EMIT0) && sof_tag_r) begin
                sof_pending_r <= 1'b0;
            end else begin
                sof_pending_r <= sof_pending_r;
            end
        end
    end

    // Emitter state register.
    always_ff @(posedge wr_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Emitter next state and the pixel word presented in each emit state.
    always_comb begin
        state_s   = state_r;
        wr_data_s = {FIFO_WIDTH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (handoff_s) begin
                    state_s = ST_EMIT0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EMIT0: begin
                state_s         = ST_EMIT1;
                wr_data_s[9:0]  = pix_buf_r[0];
                wr_data_s[10]   = sof_tag_r;
            end
            ST_EMIT1: begin
                state_s         = ST_EMIT2;
                wr_data_s[9:0]  = pix_buf_r[1];
            end
            ST_EMIT2: begin
                state_s         = ST_EMIT3;
                wr_data_s[9:0]  = pix_buf_r[2];
            end
            ST_EMIT3: begin
                state_s         = ST_IDLE;
                wr_data_s[9:0]  = pix_buf_r[3];
                wr_data_s[11]   = eol_tag_r;
            end
            default: begin
                state_s   = ST_IDLE;
                wr_data_s = {FIFO_WIDTH{1'b0}};
            end
        endcase
    end

    assign emit_s             = (state_r != ST_IDLE);
    assign wr_en_s            = emit_s & ~bus.full_o;
    assign bus.fifo_wr_en_o   = wr_en_s;
    assign bus.fifo_wr_data_o = wr_data_s;

    // Sticky overflow (set beats clear), length-error pulse and written-pixel counter.
    always_ff @(posedge wr_clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o  <= 1'b0;
            err_len_o   <= 1'b0;
            pixel_cnt_o <= {CNT_WIDTH{1'b0}};
        end else begin
            err_len_o <= err_s;
            if (emit_s && bus.full_o) begin
                overflow_o <= 1'b1;
            end else if (ovf_clr_i) begin
                overflow_o <= 1'b0;
            end else begin
                overflow_o <= overflow_o;
            end
            if (pkt_open_s) begin
                pixel_cnt_o <= {CNT_WIDTH{1'b0}};
            end else if (wr_en_s && (pixel_cnt_o != {CNT_WIDTH{1'b1}})) begin
                pixel_cnt_o <= pixel_cnt_o + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                pixel_cnt_o <= pixel_cnt_o;
            end
        end
    end

endmodule

// File: tb/tb_csi2_raw10_unpacker.sv
// Directed self-checking bench for csi2_raw10_unpacker: unpacking, tags, overflow,
// length errors and asynchronous reset during emission.
module tb_csi2_raw10_unpacker;

    logic        wr_clk_i = 1'b0;
    logic        rst_i    = 1'b0;
    logic        ovf_clr_i;
    logic        overflow_o;
    logic        err_len_o;
    logic [15:0] pixel_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int err_seen = 0;

    logic [11:0] wq [$];
    int          wc [$];

    csi2_raw10_unpacker_if #(.FIFO_WIDTH(12)) bus ();

    csi2_raw10_unpacker #(.FIFO_WIDTH(12), .CNT_WIDTH(16)) dut (
        .wr_clk_i    (wr_clk_i),
        .rst_i       (rst_i),
        .bus         (bus),
        .overflow_o  (overflow_o),
        .ovf_clr_i   (ovf_clr_i),
        .err_len_o   (err_len_o),
        .pixel_cnt_o (pixel_cnt_o)
    );

    always #5 wr_clk_i = ~wr_clk_i;

    always @(posedge wr_clk_i) cyc <= cyc + 1;

    // Record every FIFO write and every error pulse, sampled mid-cycle.
    always @(negedge wr_clk_i) begin
        if (bus.fifo_wr_en_o === 1'b1) begin
            wq.push_back(bus.fifo_wr_data_o);
            wc.push_back(cyc);
        end
        if (err_len_o === 1'b1) err_seen <= err_seen + 1;
    end

    function automatic logic [11:0] exp_px(input logic [7:0] msb, input logic [7:0] lsb,
                                           input int k, input logic sof, input logic eol);
        return {eol, sof, msb, lsb[2*k +: 2]};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge wr_clk_i);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic s, input logic e);
        bus.byte_i      = b;
        bus.byte_vld_i  = 1'b1;
        bus.pkt_start_i = s;
        bus.pkt_end_i   = e;
        @(posedge wr_clk_i);
        #1;
        bus.byte_vld_i  = 1'b0;
        bus.pkt_start_i = 1'b0;
        bus.pkt_end_i   = 1'b0;
        bus.byte_i      = 8'h00;
    endtask

    task automatic pulse_frame_start();
        bus.frame_start_i = 1'b1;
        @(posedge wr_clk_i);
        #1;
        bus.frame_start_i = 1'b0;
    endtask

    task automatic clear_log();
        wq.delete();
        wc.delete();
        err_seen = 0;
    endtask

    task automatic test_reset();
        #1 rst_i = 1'b1;
        idle(3);
        n_cmp++;
        if ({bus.fifo_wr_en_o, bus.fifo_wr_data_o, overflow_o, err_len_o, pixel_cnt_o} !== 31'd0) begin
            n_bad++;
            $display("FAIL reset_held: got %h expected 0",
                     {bus.fifo_wr_en_o, bus.fifo_wr_data_o, overflow_o, err_len_o, pixel_cnt_o});
        end
        rst_i = 1'b0;
        idle(3);
        n_cmp++;
        if ({bus.fifo_wr_en_o, bus.fifo_wr_data_o, overflow_o, err_len_o, pixel_cnt_o} !== 31'd0) begin
            n_bad++;
            $display("FAIL reset_released: got %h expected 0",
                     {bus.fifo_wr_en_o, bus.fifo_wr_data_o, overflow_o, err_len_o, pixel_cnt_o});
        end
    endtask

    task automatic test_single();
        logic [11:0] exp [4];
        int n4;
        exp = '{12'h448, 12'h0D1, 12'h15A, 12'h9E3};
        clear_log();
        pulse_frame_start();
        send(8'h12, 1'b1, 1'b0);
        send(8'h34, 1'b0, 1'b0);
        send(8'h56, 1'b0, 1'b0);
        send(8'h78, 1'b0, 1'b0);
        n4 = cyc;
        send(8'hE4, 1'b0, 1'b1);
        idle(6);
        n_cmp++;
        if (wq.size() != 4) begin
            n_bad++;
            $display("FAIL single_count: got %0d writes expected 4", wq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (wq[i] !== exp[i] || wc[i] != n4 + 1 + i) begin
                    n_bad++;
                    $display("FAIL single_px%0d: got %h at cycle %0d expected %h at cycle %0d",
                             i, wq[i], wc[i], exp[i], n4 + 1 + i);
                end
            end
        end
        n_cmp++;
        if (pixel_cnt_o !== 16'd4 || overflow_o !== 1'b0 || err_seen != 0) begin
            n_bad++;
            $display("FAIL single_status: got cnt=%0d ovf=%b err=%0d expected cnt=4 ovf=0 err=0",
                     pixel_cnt_o, overflow_o, err_seen);
        end
    endtask

    task automatic test_line();
        logic [7:0] lb [800];
        logic [11:0] e;
        int g, k;
        clear_log();
        for (int j = 0; j < 800; j++) begin
            lb[j] = 8'((j * 37 + 11) ^ (j >> 3));
            idle($urandom_range(0, 2));
            send(lb[j], (j == 0), (j == 799));
        end
        idle(6);
        n_cmp++;
        if (wq.size() != 640) begin
            n_bad++;
            $display("FAIL line_count: got %0d writes expected 640", wq.size());
        end else begin
            for (int i = 0; i < 640; i++) begin
                g = i / 4;
                k = i % 4;
                e = exp_px(lb[g*5 + k], lb[g*5 + 4], k, 1'b0, (i == 639));
                n_cmp++;
                if (wq[i] !== e) begin
                    n_bad++;
                    $display("FAIL line_px%0d: got %h expected %h", i, wq[i], e);
                end
            end
        end
        n_cmp++;
        if (pixel_cnt_o !== 16'd640 || err_seen != 0) begin
            n_bad++;
            $display("FAIL line_status: got cnt=%0d err=%0d expected cnt=640 err=0", pixel_cnt_o, err_seen);
        end
    endtask

    task automatic test_overflow();
        logic [11:0] exp [3];
        exp = '{12'h448, 12'h15A, 12'h9E3};
        clear_log();
        pulse_frame_start();
        send(8'h12, 1'b1, 1'b0);
        send(8'h34, 1'b0, 1'b0);
        send(8'h56, 1'b0, 1'b0);
        send(8'h78, 1'b0, 1'b0);
        send(8'hE4, 1'b0, 1'b1);
        idle(1);
        bus.full_o = 1'b1;
        idle(1);
        bus.full_o = 1'b0;
        idle(5);
        n_cmp++;
        if (wq.size() != 3) begin
            n_bad++;
            $display("FAIL ovf_count: got %0d writes expected 3", wq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (wq[i] !== exp[i]) begin
                    n_bad++;
                    $display("FAIL ovf_px%0d: got %h expected %h", i, wq[i], exp[i]);
                end
            end
        end
        n_cmp++;
        if (overflow_o !== 1'b1 || pixel_cnt_o !== 16'd3) begin
            n_bad++;
            $display("FAIL ovf_status: got ovf=%b cnt=%0d expected ovf=1 cnt=3", overflow_o, pixel_cnt_o);
        end
        ovf_clr_i = 1'b1;
        idle(1);
        ovf_clr_i = 1'b0;
        n_cmp++;
        if (overflow_o !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clear: got %b expected 0", overflow_o);
        end
        send(8'hA1, 1'b1, 1'b0);
        send(8'hB2, 1'b0, 1'b0);
        send(8'hC3, 1'b0, 1'b0);
        send(8'hD4, 1'b0, 1'b0);
        send(8'h1B, 1'b0, 1'b1);
        bus.full_o = 1'b1;
        ovf_clr_i  = 1'b1;
        idle(1);
        bus.full_o = 1'b0;
        ovf_clr_i  = 1'b0;
        idle(4);
        n_cmp++;
        if (overflow_o !== 1'b1 || pixel_cnt_o !== 16'd3) begin
            n_bad++;
            $display("FAIL ovf_set_wins: got ovf=%b cnt=%0d expected ovf=1 cnt=3", overflow_o, pixel_cnt_o);
        end
        ovf_clr_i = 1'b1;
        idle(1);
        ovf_clr_i = 1'b0;
    endtask

    task automatic test_short_pkt();
        logic [7:0] g1 [5];
        logic [7:0] g2 [5];
        logic [11:0] e;
        g1 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        g2 = '{8'h9C, 8'h5A, 8'hF0, 8'h3E, 8'h6D};
        clear_log();
        for (int j = 0; j < 5; j++) send(g1[j], (j == 0), 1'b0);
        send(8'hAA, 1'b0, 1'b0);
        send(8'hBB, 1'b0, 1'b1);
        idle(3);
        for (int j = 0; j < 5; j++) send(g2[j], (j == 0), (j == 4));
        idle(6);
        n_cmp++;
        if (wq.size() != 8 || err_seen != 1) begin
            n_bad++;
            $display("FAIL short_counts: got %0d writes, %0d err pulses expected 8 and 1", wq.size(), err_seen);
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (i < 4) e = exp_px(g1[i], g1[4], i, 1'b0, 1'b0);
                else       e = exp_px(g2[i-4], g2[4], i - 4, 1'b0, (i == 7));
                n_cmp++;
                if (wq[i] !== e) begin
                    n_bad++;
                    $display("FAIL short_px%0d: got %h expected %h", i, wq[i], e);
                end
            end
        end
    endtask

    task automatic test_restart();
        logic [7:0] g [5];
        logic [11:0] e;
        g = '{8'h44, 8'h55, 8'h66, 8'h77, 8'h8D};
        clear_log();
        send(8'h11, 1'b1, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h33, 1'b0, 1'b0);
        for (int j = 0; j < 5; j++) send(g[j], (j == 0), (j == 4));
        idle(6);
        n_cmp++;
        if (wq.size() != 4 || err_seen != 1) begin
            n_bad++;
            $display("FAIL restart_counts: got %0d writes, %0d err pulses expected 4 and 1", wq.size(), err_seen);
        end else begin
            for (int i = 0; i < 4; i++) begin
                e = exp_px(g[i], g[4], i, 1'b0, (i == 3));
                n_cmp++;
                if (wq[i] !== e) begin
                    n_bad++;
                    $display("FAIL restart_px%0d: got %h expected %h", i, wq[i], e);
                end
            end
        end
        n_cmp++;
        if (pixel_cnt_o !== 16'd4) begin
            n_bad++;
            $display("FAIL restart_cnt: got %0d expected 4", pixel_cnt_o);
        end
    endtask

    task automatic test_mid_reset();
        clear_log();
        pulse_frame_start();
        send(8'h12, 1'b1, 1'b0);
        send(8'h34, 1'b0, 1'b0);
        send(8'h56, 1'b0, 1'b0);
        send(8'h78, 1'b0, 1'b0);
        send(8'hE4, 1'b0, 1'b1);
        idle(1);
        rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({bus.fifo_wr_en_o, bus.fifo_wr_data_o, overflow_o, err_len_o, pixel_cnt_o} !== 31'd0) begin
            n_bad++;
            $display("FAIL midrst_outputs: got %h expected 0",
                     {bus.fifo_wr_en_o, bus.fifo_wr_data_o, overflow_o, err_len_o, pixel_cnt_o});
        end
        idle(2);
        rst_i = 1'b0;
        idle(5);
        n_cmp++;
        if (wq.size() != 1 || pixel_cnt_o !== 16'd0) begin
            n_bad++;
            $display("FAIL midrst_writes: got %0d writes cnt=%0d expected 1 write cnt=0", wq.size(), pixel_cnt_o);
        end
    endtask

    initial begin
        bus.byte_i        = 8'h00;
        bus.byte_vld_i    = 1'b0;
        bus.pkt_start_i   = 1'b0;
        bus.pkt_end_i     = 1'b0;
        bus.frame_start_i = 1'b0;
        bus.full_o        = 1'b0;
        ovf_clr_i         = 1'b0;
        test_reset();
        test_single();
        test_line();
        test_overflow();
        test_short_pkt();
        test_restart();
        test_mid_reset();
        test_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
